// File: rtl/blob_tracker_if.sv
// Target request channel into the blob tracker.
// A target transfers on a rising clock edge where target_valid and target_ready are both high;
// target_x/target_y must be stable while target_valid is high, and ready does not depend on valid.
interface blob_tracker_if;
    logic signed [11:0] target_x;
    logic signed [11:0] target_y;
    logic               target_valid;
    logic               target_ready;

    modport master (
        output target_x,
        output target_y,
        output target_valid,
        input  target_ready
    );

    modport slave (
        input  target_x,
        input  target_y,
        input  target_valid,
        output target_ready
    );
endinterface

// File: rtl/blob_tracker.sv
// Moves a blob centre toward a clamped target by at most STEP pixels per axis per frame,
// updating only right after a vsync falling edge so the blob never moves mid-frame.
module blob_tracker #(
    parameter int SCREEN_W = 1024,
    parameter int SCREEN_H = 768,
    parameter int HALF_W   = 32,
    parameter int HALF_H   = 32,
    parameter int STEP     = 4,
    parameter int INIT_X   = 512,
    parameter int INIT_Y   = 384
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               vsync,
    blob_tracker_if.slave      tgt,
    output logic signed [11:0] x,
    output logic signed [11:0] y,
    output logic               moving,
    output logic               arrived,
    output logic               state_o
);

    typedef enum logic {IDLE = 1'b0, MOVING = 1'b1} state_t;

    localparam logic signed [12:0] X_LO   = 13'(HALF_W);
    localparam logic signed [12:0] X_HI   = 13'(SCREEN_W - 1 - HALF_W);
    localparam logic signed [12:0] Y_LO   = 13'(HALF_H);
    localparam logic signed [12:0] Y_HI   = 13'(SCREEN_H - 1 - HALF_H);
    localparam logic signed [12:0] STEP13 = 13'(STEP);
    localparam logic signed [11:0] STEP12 = 12'(STEP);
    localparam logic signed [11:0] INIT_X12 = 12'(INIT_X);
    localparam logic signed [11:0] INIT_Y12 = 12'(INIT_Y);

    state_t             state_q, state_d;
    logic signed [11:0] x_q, x_d, y_q, y_d;
    logic signed [11:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic               moving_q, moving_d;
    logic               arrived_q, arrived_d;
    logic               vsync_q;
    logic               ready_q;

    logic               frame_tick;
    logic               capture;
    logic signed [11:0] clamp_x, clamp_y;
    logic signed [11:0] step_x, step_y;

    function automatic logic signed [11:0] clamp(
        input logic signed [11:0] v,
        input logic signed [12:0] lo,
        input logic signed [12:0] hi
    );
        logic signed [12:0] w;
        w = {v[11], v};
        if (w < lo)      return lo[11:0];
        else if (w > hi) return hi[11:0];
        else             return v;
    endfunction

    // 13-bit difference so the full 12-bit signed range cannot overflow.
    function automatic logic signed [11:0] step_toward(
        input logic signed [11:0] cur,
        input logic signed [11:0] dst
    );
        logic signed [12:0] diff;
        diff = {dst[11], dst} - {cur[11], cur};
        if (diff <= STEP13 && diff >= -STEP13) return dst;
        else if (diff > 13'sd0)                return cur + STEP12;
        else                                   return cur - STEP12;
    endfunction

    // ready_q is low for the first edge after reset, which also blocks a tick
    // when vsync was already low at release.
    assign frame_tick = vsync_q & ~vsync & ready_q;
    assign capture    = tgt.target_valid & ready_q;
    assign clamp_x    = clamp(tgt.target_x, X_LO, X_HI);
    assign clamp_y    = clamp(tgt.target_y, Y_LO, Y_HI);
    assign step_x     = step_toward(x_q, tgt_x_q);
    assign step_y     = step_toward(y_q, tgt_y_q);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        tgt_x_d   = tgt_x_q;
        tgt_y_d   = tgt_y_q;
        arrived_d = 1'b0;

        if (state_q == MOVING && frame_tick) begin
            x_d = step_x;
            y_d = step_y;
            if (step_x == tgt_x_q && step_y == tgt_y_q) begin
                state_d   = IDLE;
                arrived_d = 1'b1;
            end
        end

        // A capture is judged against the post-step position, so a coincident
        // tick finishes the old move before the new target applies.
        if (capture) begin
            tgt_x_d = clamp_x;
            tgt_y_d = clamp_y;
            if (clamp_x != x_d || clamp_y != y_d) begin
                state_d   = MOVING;
                arrived_d = 1'b0;
            end else begin
                state_d   = IDLE;
                arrived_d = 1'b1;
            end
        end

        moving_d = (state_d == MOVING);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= INIT_X12;
            y_q       <= INIT_Y12;
            tgt_x_q   <= INIT_X12;
            tgt_y_q   <= INIT_Y12;
            moving_q  <= 1'b0;
            arrived_q <= 1'b0;
            vsync_q   <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            tgt_x_q   <= tgt_x_d;
            tgt_y_q   <= tgt_y_d;
            moving_q  <= moving_d;
            arrived_q <= arrived_d;
            vsync_q   <= vsync;
            ready_q   <= 1'b1;
        end
    end

    assign x                = x_q;
    assign y                = y_q;
    assign moving           = moving_q;
    assign arrived          = arrived_q;
    assign state_o          = (state_q == MOVING);
    assign tgt.target_ready = ready_q;

endmodule

// File: tb/tb_blob_tracker.sv
// Self-checking bench for blob_tracker: directed scenarios plus randomized traffic
// compared against a frame-level position model.
module tb_blob_tracker;

    localparam int STEP = 4;
    localparam int X_LO = 32;
    localparam int X_HI = 991;
    localparam int Y_LO = 32;
    localparam int Y_HI = 735;

    logic               clock = 1'b0;
    logic               reset;
    logic               vsync;
    logic signed [11:0] x, y;
    logic               moving, arrived, state_dbg;

    blob_tracker_if bif ();

    blob_tracker dut (
        .clock   (clock),
        .reset   (reset),
        .vsync   (vsync),
        .tgt     (bif),
        .x       (x),
        .y       (y),
        .moving  (moving),
        .arrived (arrived),
        .state_o (state_dbg)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position, target, motion flag, last-edge arrival.
    int mx, my, mtx, mty;
    bit m_mov, m_arr, m_ready, m_vs;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int stepi(input int c, input int t);
        int d;
        d = t - c;
        if (d <= STEP && d >= -STEP) return t;
        return (d > 0) ? c + STEP : c - STEP;
    endfunction

    task automatic model_reset();
        mx = 512; my = 384; mtx = 512; mty = 384;
        m_mov = 0; m_arr = 0; m_ready = 0; m_vs = 1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        vsync = 1'b1;
        bif.target_valid = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One clock: drive at negedge, advance model on posedge, settle #1.
    task automatic drive_cycle(input bit vs, input bit cap, input int tx, input int ty);
        bit tick, cap_eff;
        @(negedge clock);
        vsync = vs;
        bif.target_valid = cap;
        bif.target_x = 12'(tx);
        bif.target_y = 12'(ty);
        @(posedge clock);
        tick    = m_ready && m_vs && !vs;
        cap_eff = m_ready && cap;
        m_arr = 0;
        if (tick && m_mov) begin
            mx = stepi(mx, mtx);
            my = stepi(my, mty);
            if (mx == mtx && my == mty) begin
                m_mov = 0;
                m_arr = 1;
            end
        end
        if (cap_eff) begin
            mtx = clampi(tx, X_LO, X_HI);
            mty = clampi(ty, Y_LO, Y_HI);
            m_mov = (mtx != mx) || (mty != my);
            m_arr = !m_mov;
        end
        m_ready = 1;
        m_vs = vs;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        vsync = 1'b1;
        bif.target_valid = 1'b0;
        bif.target_x = '0;
        bif.target_y = '0;
        model_reset();
        #1;
        n_cmp++; if (x !== 12'sd512) begin n_err++; $display("FAIL reset_x: got %0d want 512", x); end
        n_cmp++; if (y !== 12'sd384) begin n_err++; $display("FAIL reset_y: got %0d want 384", y); end
        n_cmp++; if (moving !== 1'b0) begin n_err++; $display("FAIL reset_moving: got %b want 0", moving); end
        n_cmp++; if (arrived !== 1'b0) begin n_err++; $display("FAIL reset_arrived: got %b want 0", arrived); end
        n_cmp++; if (bif.target_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bif.target_ready); end
        @(negedge clock);
        reset = 1'b0;
        drive_cycle(1, 0, 0, 0);
        n_cmp++; if (bif.target_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %b want 1", bif.target_ready); end
    endtask

    task automatic test_move_from_reset();
        do_reset();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 1, 600, 384);
        n_cmp++; if (moving !== 1'b1) begin n_err++; $display("FAIL move_start: moving got %b want 1", moving); end
        for (int i = 1; i <= 22; i++) begin
            drive_cycle(0, 0, 0, 0);
            n_cmp++; if (x !== 12'(512 + 4 * i)) begin n_err++; $display("FAIL move_x[%0d]: got %0d want %0d", i, x, 512 + 4 * i); end
            n_cmp++; if (arrived !== (i == 22)) begin n_err++; $display("FAIL move_arrived[%0d]: got %b want %b", i, arrived, i == 22); end
            n_cmp++; if (moving !== (i != 22)) begin n_err++; $display("FAIL move_moving[%0d]: got %b want %b", i, moving, i != 22); end
            drive_cycle(1, 0, 0, 0);
            n_cmp++; if (arrived !== 1'b0) begin n_err++; $display("FAIL move_arrived_len[%0d]: got %b want 0", i, arrived); end
        end
        n_cmp++; if (y !== 12'sd384) begin n_err++; $display("FAIL move_y: got %0d want 384", y); end
    endtask

    task automatic test_residual();
        do_reset();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 1, 514, 390);
        drive_cycle(0, 0, 0, 0);
        n_cmp++; if (x !== 12'sd514 || y !== 12'sd388) begin n_err++; $display("FAIL residual_1: got (%0d,%0d) want (514,388)", x, y); end
        n_cmp++; if (arrived !== 1'b0) begin n_err++; $display("FAIL residual_1_arr: got %b want 0", arrived); end
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        n_cmp++; if (x !== 12'sd514 || y !== 12'sd390) begin n_err++; $display("FAIL residual_2: got (%0d,%0d) want (514,390)", x, y); end
        n_cmp++; if (arrived !== 1'b1 || moving !== 1'b0) begin n_err++; $display("FAIL residual_2_arr: got arr=%b mov=%b want arr=1 mov=0", arrived, moving); end
    endtask

    task automatic test_clamp();
        int frames, arrivals;
        do_reset();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 1, -50, 2000);
        frames = 0;
        arrivals = 0;
        while (moving === 1'b1 && frames < 400) begin
            drive_cycle(0, 0, 0, 0);
            if (arrived === 1'b1) arrivals++;
            drive_cycle(1, 0, 0, 0);
            frames++;
        end
        n_cmp++; if (frames >= 400) begin n_err++; $display("FAIL clamp_timeout: frames %0d want < 400", frames); end
        n_cmp++; if (x !== 12'sd32 || y !== 12'sd735) begin n_err++; $display("FAIL clamp_final: got (%0d,%0d) want (32,735)", x, y); end
        n_cmp++; if (frames != 120) begin n_err++; $display("FAIL clamp_frames: got %0d want 120", frames); end
        n_cmp++; if (arrivals != 1) begin n_err++; $display("FAIL clamp_arrivals: got %0d want 1", arrivals); end
    endtask

    task automatic test_retarget();
        int frames;
        bit early;
        do_reset();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 1, 600, 384);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, 0, 0);
            drive_cycle(1, 0, 0, 0);
        end
        n_cmp++; if (x !== 12'sd524) begin n_err++; $display("FAIL retarget_pre: got %0d want 524", x); end
        drive_cycle(1, 1, 500, 384);
        drive_cycle(0, 0, 0, 0);
        n_cmp++; if (x !== 12'sd520) begin n_err++; $display("FAIL retarget_first: got %0d want 520", x); end
        early = 0;
        frames = 0;
        while (x !== 12'sd500 && frames < 50) begin
            if (arrived === 1'b1) early = 1;
            drive_cycle(1, 0, 0, 0);
            drive_cycle(0, 0, 0, 0);
            frames++;
        end
        if (x !== 12'sd500 && arrived === 1'b1) early = 1;
        n_cmp++; if (early) begin n_err++; $display("FAIL retarget_early_arrived: got 1 want 0"); end
        n_cmp++; if (x !== 12'sd500 || arrived !== 1'b1) begin n_err++; $display("FAIL retarget_final: got x=%0d arr=%b want x=500 arr=1", x, arrived); end
    endtask

    task automatic test_coincident();
        do_reset();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 1, 520, 384);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0);
        n_cmp++; if (x !== 12'sd516) begin n_err++; $display("FAIL coinc_pre: got %0d want 516", x); end
        drive_cycle(0, 1, 400, 384);
        n_cmp++; if (x !== 12'sd520) begin n_err++; $display("FAIL coinc_x: got %0d want 520", x); end
        n_cmp++; if (arrived !== 1'b0 || moving !== 1'b1) begin n_err++; $display("FAIL coinc_flags: got arr=%b mov=%b want arr=0 mov=1", arrived, moving); end
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        n_cmp++; if (x !== 12'sd516) begin n_err++; $display("FAIL coinc_next: got %0d want 516", x); end
    endtask

    task automatic test_same_pos();
        do_reset();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 1, 512, 384);
        n_cmp++; if (arrived !== 1'b1 || moving !== 1'b0) begin n_err++; $display("FAIL same_pos_flags: got arr=%b mov=%b want arr=1 mov=0", arrived, moving); end
        drive_cycle(1, 0, 0, 0);
        n_cmp++; if (arrived !== 1'b0) begin n_err++; $display("FAIL same_pos_pulse: got %b want 0", arrived); end
        drive_cycle(0, 0, 0, 0);
        n_cmp++; if (x !== 12'sd512 || y !== 12'sd384 || arrived !== 1'b0) begin n_err++; $display("FAIL idle_tick: got (%0d,%0d) arr=%b want (512,384) arr=0", x, y, arrived); end
    endtask

    task automatic test_reset_mid_move();
        bit bad;
        do_reset();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 1, 700, 500);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 0, 0, 0);
            drive_cycle(1, 0, 0, 0);
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
        vsync = 1'b1;
        bif.target_valid = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (x !== 12'sd512 || y !== 12'sd384 || moving !== 1'b0) begin n_err++; $display("FAIL midreset_now: got (%0d,%0d) mov=%b want (512,384) mov=0", x, y, moving); end
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            drive_cycle(0, 0, 0, 0);
            if (arrived !== 1'b0 || x !== 12'sd512 || y !== 12'sd384) bad = 1;
            drive_cycle(1, 0, 0, 0);
            if (arrived !== 1'b0) bad = 1;
        end
        n_cmp++; if (bad) begin n_err++; $display("FAIL midreset_after: got x=%0d y=%0d arr=%b want (512,384) arr=0", x, y, arrived); end
    endtask

    task automatic test_random();
        bit vs, cap;
        int tx, ty;
        do_reset();
        drive_cycle(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            vs  = ($urandom_range(0, 3) != 0);
            cap = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tx = mx + int'($urandom_range(0, 12)) - 6;
                ty = my + int'($urandom_range(0, 12)) - 6;
            end else begin
                tx = int'($urandom_range(0, 2140)) - 100;
                ty = int'($urandom_range(0, 2140)) - 100;
            end
            drive_cycle(vs, cap, tx, ty);
            n_cmp++;
            if (x !== 12'(mx) || y !== 12'(my) || moving !== m_mov || arrived !== m_arr || state_dbg !== m_mov) begin
                n_err++;
                $display("FAIL random[%0d]: got (%0d,%0d) mov=%b arr=%b st=%b want (%0d,%0d) mov=%b arr=%b",
                         i, x, y, moving, arrived, state_dbg, mx, my, m_mov, m_arr);
            end
            n_cmp++;
            if (x < X_LO || x > X_HI || y < Y_LO || y > Y_HI) begin
                n_err++;
                $display("FAIL random_bounds[%0d]: got (%0d,%0d) want within [%0d..%0d]x[%0d..%0d]", i, x, y, X_LO, X_HI, Y_LO, Y_HI);
            end
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        vsync = 1'b1;
        bif.target_valid = 1'b0;
        bif.target_x = '0;
        bif.target_y = '0;
        model_reset();
        test_reset();
        test_move_from_reset();
        test_residual();
        test_clamp();
        test_retarget();
        test_coincident();
        test_same_pos();
        test_reset_mid_move();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
